// File: rtl/angle_spi_pkg.sv
// Shared constants, FSM state type and parity helper for the angle sensor SPI responder.
// Build option: ANGLE_RESP_STATS_EN adds the statistics register address.
package angle_spi_pkg;

    localparam int FRAME_W = 16;

    localparam logic [13:0] ADDR_ANGLE   = 14'h3FFF;
    localparam logic [13:0] ADDR_MAG     = 14'h3FFE;
    localparam logic [13:0] ADDR_DIAG    = 14'h3FFD;
    localparam logic [13:0] ADDR_CLR_ERR = 14'h0001;
`ifdef ANGLE_RESP_STATS_EN
    localparam logic [13:0] ADDR_STATS   = 14'h3FFC;
`endif

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DECODE
    } state_t;

    // Returns 1 when the word has an odd number of ones.
    function automatic logic even_parity16(input logic [15:0] w);
        return ^w;
    endfunction

endpackage

// File: rtl/spi_input_sync.sv
// N-stage synchronizer with registered rise/fall pulses; level output is aligned with the pulses.
module spi_input_sync #(
    parameter int STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_pin,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;
    logic              r_rise;
    logic              r_fall;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_pin};
            r_prev <= r_sync[STAGES-1];
            r_rise <= r_sync[STAGES-1] & ~r_prev;
            r_fall <= ~r_sync[STAGES-1] & r_prev;
        end
    end

    assign o_level = r_prev;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;

endmodule

// File: rtl/angle_sensor_spi_responder.sv
// AS5048A-style SPI mode-1 responder: answers 16-bit read commands one frame later.
// Build option: ANGLE_RESP_STATS_EN adds frame/error counters and the 3FFC read address.
module angle_sensor_spi_responder
    import angle_spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int ANGLE_W     = 14
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_sck,
    input  logic               i_ss_n,
    input  logic               i_mosi,
    output logic               o_miso,
    output logic               o_miso_oe,
    input  logic [ANGLE_W-1:0] i_angle,
    input  logic               i_angle_valid,
    input  logic [ANGLE_W-1:0] i_magnitude,
    output logic               o_frame_done,
    output logic [FRAME_W-1:0] o_last_cmd,
    output logic               o_error_flag
`ifdef ANGLE_RESP_STATS_EN
    ,
    output logic [15:0]        o_frame_count,
    output logic [15:0]        o_error_count
`endif
);

    logic [2:0] w_pins;
    logic [2:0] w_level;
    logic [2:0] w_rise;
    logic [2:0] w_fall;

    assign w_pins = {i_mosi, i_ss_n, i_sck};

    for (genvar gi = 0; gi < 3; gi++) begin : g_sync
        spi_input_sync #(.STAGES(SYNC_STAGES)) u_sync (
            .i_clk   (i_clk),
            .i_rst   (i_rst),
            .i_pin   (w_pins[gi]),
            .o_level (w_level[gi]),
            .o_rise  (w_rise[gi]),
            .o_fall  (w_fall[gi])
        );
    end

    logic w_unused;
    assign w_unused = ^{w_level[0], w_rise[2], w_fall[2]};

    state_t             r_state;
    state_t             w_state_next;
    logic               r_armed;
    logic [FRAME_W-1:0] r_tx_shift;
    logic [FRAME_W-1:0] r_rx_shift;
    logic [FRAME_W-1:0] r_pending;
    logic [FRAME_W-1:0] r_last_cmd;
    logic [4:0]         r_bit_cnt;
    logic [ANGLE_W-1:0] r_angle;
    logic               r_miso;
    logic               r_miso_oe;
    logic               r_frame_done;
    logic               r_err_framing;
    logic               r_err_invalid;
    logic               r_err_parity;
`ifdef ANGLE_RESP_STATS_EN
    logic [15:0]        r_frame_count;
    logic [15:0]        r_error_count;
`endif

    logic               w_frame_ok;
    logic [13:0]        w_data;
    logic               w_set_parity;
    logic               w_set_invalid;
    logic               w_clear_err;
    logic               w_ef_after;
    logic [FRAME_W-1:0] w_resp_body;
    logic [FRAME_W-1:0] w_resp;

    assign o_error_flag = r_err_framing | r_err_invalid | r_err_parity;
    assign w_frame_ok   = (r_bit_cnt == 5'd16);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next  = r_state;
        w_data        = '0;
        w_set_parity  = 1'b0;
        w_set_invalid = 1'b0;
        w_clear_err   = 1'b0;
        case (r_state)
            IDLE:    if (r_armed && w_fall[1]) w_state_next = SHIFT;
            SHIFT:   if (w_rise[1]) w_state_next = DECODE;
            DECODE:  w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
        if (even_parity16(r_rx_shift)) begin
            w_set_parity = 1'b1;
        end else if (!r_rx_shift[14]) begin
            w_set_invalid = 1'b1;
        end else begin
            case (r_rx_shift[13:0])
                // A strobe coinciding with the decode wins over the stored sample.
                ADDR_ANGLE:   w_data = i_angle_valid ? i_angle : r_angle;
                ADDR_MAG:     w_data = i_magnitude;
                ADDR_DIAG:    w_data = {12'b0, o_error_flag, 1'b0};
                ADDR_CLR_ERR: begin
                    w_data      = {11'b0, r_err_framing, r_err_invalid, r_err_parity};
                    w_clear_err = 1'b1;
                end
`ifdef ANGLE_RESP_STATS_EN
                ADDR_STATS:   w_data = r_frame_count[13:0];
`endif
                default:      w_set_invalid = 1'b1;
            endcase
        end
        w_ef_after  = w_clear_err ? 1'b0 : (o_error_flag | w_set_parity | w_set_invalid);
        w_resp_body = {1'b0, w_ef_after, w_data};
        w_resp      = {even_parity16(w_resp_body), w_resp_body[14:0]};
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_armed       <= 1'b0;
            r_tx_shift    <= '0;
            r_rx_shift    <= '0;
            r_pending     <= '0;
            r_last_cmd    <= '0;
            r_bit_cnt     <= '0;
            r_angle       <= '0;
            r_miso        <= 1'b0;
            r_miso_oe     <= 1'b0;
            r_frame_done  <= 1'b0;
            r_err_framing <= 1'b0;
            r_err_invalid <= 1'b0;
            r_err_parity  <= 1'b0;
`ifdef ANGLE_RESP_STATS_EN
            r_frame_count <= '0;
            r_error_count <= '0;
`endif
        end else begin
            r_frame_done <= 1'b0;
            if (i_angle_valid) r_angle <= i_angle;
            // After reset the bus is ignored until chip select has been seen idle.
            if (w_level[1]) r_armed <= 1'b1;
            case (r_state)
                IDLE: begin
                    if (w_state_next == SHIFT) begin
                        r_tx_shift <= r_pending;
                        r_bit_cnt  <= '0;
                        r_miso_oe  <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (w_rise[0]) begin
                        r_miso     <= r_tx_shift[15];
                        r_tx_shift <= {r_tx_shift[14:0], 1'b0};
                    end
                    if (w_fall[0]) begin
                        r_rx_shift <= {r_rx_shift[14:0], w_level[2]};
                        if (r_bit_cnt != 5'd17) r_bit_cnt <= r_bit_cnt + 5'd1;
                    end
                end
                DECODE: begin
                    r_miso_oe <= 1'b0;
                    if (w_frame_ok) begin
                        r_last_cmd   <= r_rx_shift;
                        r_frame_done <= 1'b1;
                        r_pending    <= w_resp;
                        if (w_clear_err) begin
                            r_err_framing <= 1'b0;
                            r_err_invalid <= 1'b0;
                            r_err_parity  <= 1'b0;
                        end else begin
                            if (w_set_parity)  r_err_parity  <= 1'b1;
                            if (w_set_invalid) r_err_invalid <= 1'b1;
                        end
                    end else begin
                        r_err_framing <= 1'b1;
                    end
`ifdef ANGLE_RESP_STATS_EN
                    if (w_frame_ok) r_frame_count <= r_frame_count + 16'd1;
                    if (!w_frame_ok || w_set_parity || w_set_invalid)
                        r_error_count <= r_error_count + 16'd1;
`endif
                end
                default: ;
            endcase
        end
    end

    assign o_miso       = r_miso;
    assign o_miso_oe    = r_miso_oe;
    assign o_frame_done = r_frame_done;
    assign o_last_cmd   = r_last_cmd;
`ifdef ANGLE_RESP_STATS_EN
    assign o_frame_count = r_frame_count;
    assign o_error_count = r_error_count;
`endif

endmodule

// File: tb/tb_angle_sensor_spi_responder.sv
// Scoreboard bench: frames push {cmd, expected reply}; a monitor checks them on each frame_done.
module tb_angle_sensor_spi_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        sck;
    logic        ss_n;
    logic        mosi;
    logic        miso;
    logic        miso_oe;
    logic [13:0] angle;
    logic        angle_valid;
    logic [13:0] magnitude;
    logic        frame_done;
    logic [15:0] last_cmd;
    logic        error_flag;
`ifdef ANGLE_RESP_STATS_EN
    logic [15:0] frame_count;
    logic [15:0] error_count;
`endif

    angle_sensor_spi_responder #(.SYNC_STAGES(2), .ANGLE_W(14)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_sck         (sck),
        .i_ss_n        (ss_n),
        .i_mosi        (mosi),
        .o_miso        (miso),
        .o_miso_oe     (miso_oe),
        .i_angle       (angle),
        .i_angle_valid (angle_valid),
        .i_magnitude   (magnitude),
        .o_frame_done  (frame_done),
        .o_last_cmd    (last_cmd),
        .o_error_flag  (error_flag)
`ifdef ANGLE_RESP_STATS_EN
        ,
        .o_frame_count (frame_count),
        .o_error_count (error_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] cmd;
        logic [15:0] resp;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    logic [15:0] miso_word;
    int          tests = 0;
    int          fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Mode 1 master: drive mosi on sck rise, sample miso just before sck fall.
    task automatic spi_xfer(input logic [15:0] cmd, input int nbits);
        logic [15:0] rx;
        rx   = '0;
        ss_n = 1'b0;
        wait_clks(8);
        for (int b = 0; b < nbits; b++) begin
            sck  = 1'b1;
            mosi = cmd[15-b];
            wait_clks(8);
            rx   = {rx[14:0], miso};
            sck  = 1'b0;
            wait_clks(8);
        end
        miso_word = rx;
        ss_n = 1'b1;
        wait_clks(16);
        $display("[TB] xfer cmd=0x%04h bits=%0d miso=0x%04h", cmd, nbits, rx);
    endtask

    task automatic frame(input logic [15:0] cmd, input logic [15:0] resp);
        exp_t e;
        e.cmd  = cmd;
        e.resp = resp;
        sb_q.push_back(e);
        spi_xfer(cmd, 16);
    endtask

    always @(negedge clk) begin
        if (!rst && frame_done) begin
            if (sb_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_frame_done: last_cmd=0x%04h, expected no frame", last_cmd);
            end else begin
                mon_e = sb_q.pop_front();
                check("last_cmd", {16'h0, last_cmd}, {16'h0, mon_e.cmd});
                check("miso_resp", {16'h0, miso_word}, {16'h0, mon_e.resp});
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; sck = 1'b0; ss_n = 1'b1; mosi = 1'b0;
        angle = '0; angle_valid = 1'b0; magnitude = '0;
        wait_clks(4);
        check("rst_miso", {31'h0, miso}, 32'h0);
        check("rst_miso_oe", {31'h0, miso_oe}, 32'h0);
        check("rst_frame_done", {31'h0, frame_done}, 32'h0);
        check("rst_last_cmd", {16'h0, last_cmd}, 32'h0);
        check("rst_error_flag", {31'h0, error_flag}, 32'h0);
        rst = 1'b0;
        wait_clks(8);

        angle = 14'h1234; angle_valid = 1'b1;
        wait_clks(1);
        angle_valid = 1'b0; angle = 14'h0AAA;

        // Short frame: framing error, no frame_done, pending reply untouched.
        spi_xfer(16'hFFFF, 8);
        check("partial_miso", {16'h0, miso_word}, 32'h0);
        check("err_after_partial", {31'h0, error_flag}, 32'h1);
        frame(16'hFFFF, 16'h0000);

        magnitude = 14'h0155;
        frame(16'h7FFE, 16'h5234);
        frame(16'h0000, 16'h4155);
        check("err_after_invalid", {31'h0, error_flag}, 32'h1);
        frame(16'h4001, 16'hC000);
        check("err_after_clear", {31'h0, error_flag}, 32'h0);
        frame(16'hFFFF, 16'h0006);
        frame(16'hFFFF, 16'h9234);
        check("err_after_angle", {31'h0, error_flag}, 32'h0);
        frame(16'h7FFF, 16'h9234);
        check("err_after_parity", {31'h0, error_flag}, 32'h1);
        frame(16'h7FFD, 16'hC000);
        frame(16'h4001, 16'h4002);
        check("err_after_clear2", {31'h0, error_flag}, 32'h0);
        frame(16'hFFFF, 16'h8001);
`ifdef ANGLE_RESP_STATS_EN
        check("frame_count", {16'h0, frame_count}, 32'd10);
        check("error_count", {16'h0, error_count}, 32'd3);
`endif

        // Reset in the middle of a frame, then hold ss_n low after release.
        ss_n = 1'b0;
        wait_clks(8);
        for (int b = 0; b < 5; b++) begin
            sck = 1'b1; mosi = 1'b1; wait_clks(8);
            sck = 1'b0; wait_clks(8);
        end
        sck = 1'b1;
        wait_clks(4);
        check("oe_in_frame", {31'h0, miso_oe}, 32'h1);
        rst = 1'b1;
        #1;
        check("oe_after_rst", {31'h0, miso_oe}, 32'h0);
        check("last_cmd_after_rst", {16'h0, last_cmd}, 32'h0);
        check("err_after_rst", {31'h0, error_flag}, 32'h0);
        sck = 1'b0;
        wait_clks(3);
        rst = 1'b0;
        wait_clks(8);
        for (int b = 0; b < 16; b++) begin
            sck = 1'b1; wait_clks(8);
            sck = 1'b0; wait_clks(8);
        end
        check("oe_ss_held_low", {31'h0, miso_oe}, 32'h0);
        ss_n = 1'b1;
        wait_clks(16);
        frame(16'hFFFF, 16'h0000);
        frame(16'hFFFF, 16'h0000);
        check("err_end", {31'h0, error_flag}, 32'h0);

        wait_clks(10);
        check("sb_empty", sb_q.size(), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
